// File: rtl/control_sequencer_if.sv
// Bus bundle between the control sequencer and the datapath: fetch/decode
// inputs plus every strobe the sequencer issues.
interface control_sequencer_if;
   logic        run;
   logic        mem_ready;
   logic [31:0] IR;

   logic        PCout, Zlowout, Zhighout, MDRout;
   logic [15:0] Rout;
   logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
   logic [15:0] Rin;
   logic        IncPC, Read;
   logic [4:0]  alu_op;
   logic        halted, illegal;

   modport master (
      input  run, mem_ready, IR,
      output PCout, Zlowout, Zhighout, MDRout, Rout,
             MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, Rin,
             IncPC, Read, alu_op, halted, illegal
   );

   modport slave (
      output run, mem_ready, IR,
      input  PCout, Zlowout, Zhighout, MDRout, Rout,
             MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high, Rin,
             IncPC, Read, alu_op, halted, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer issuing one-hot datapath strobes
// for ALU, unary, mul/div, nop and halt instructions.
module control_sequencer (
   input logic                   Clock,
   input logic                   clear,
   control_sequencer_if.master   bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_bin, is_un, is_md, is_nop, is_hlt;

   assign opcode = bus.IR[31:27];
   assign ra     = bus.IR[26:23];
   assign rb     = bus.IR[22:19];
   assign rc     = bus.IR[18:15];

   assign is_bin = (opcode >= 5'h03) && (opcode <= 5'h0A);
   assign is_un  = (opcode == 5'h11) || (opcode == 5'h12);
   assign is_md  = (opcode == 5'h0F) || (opcode == 5'h10);
   assign is_nop = (opcode == 5'h1B);
   assign is_hlt = (opcode == 5'h1C);

   always_ff @(posedge Clock) begin
      if (!clear) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      bus.PCout    = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Rout     = '0;
      bus.MARin    = 1'b0;
      bus.PCin     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.Zin_low  = 1'b0;
      bus.Zin_high = 1'b0;
      bus.Rin      = '0;
      bus.IncPC    = 1'b0;
      bus.Read     = 1'b0;
      bus.alu_op   = '0;
      bus.halted   = 1'b0;
      bus.illegal  = illegal_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_T0;
         end
         S_T0: begin
            bus.PCout   = 1'b1;
            bus.MARin   = 1'b1;
            bus.IncPC   = 1'b1;
            bus.Zin_low = 1'b1;
            bus.alu_op  = 5'h03;
            state_d     = S_T1;
         end
         S_T1: begin
            // PC is loaded only on the exit cycle so a memory wait cannot double-increment it
            bus.Zlowout = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            bus.PCin    = bus.mem_ready;
            if (bus.mem_ready) state_d = S_T2;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = S_T3;
         end
         S_T3: begin
            if (is_nop) begin
               state_d = S_T0;
            end else if (is_hlt) begin
               state_d = S_HALT;
            end else if (is_bin || is_un || is_md) begin
               bus.Rout = 16'b1 << rb;
               bus.Yin  = 1'b1;
               state_d  = S_T4;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_T4: begin
            // unary ops take their single operand from Y, so nothing drives the bus
            if (!is_un) bus.Rout = 16'b1 << rc;
            bus.alu_op   = opcode;
            bus.Zin_low  = 1'b1;
            bus.Zin_high = 1'b1;
            state_d      = S_T5;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (is_md) begin
               bus.LOin = 1'b1;
               state_d  = S_T6;
            end else begin
               bus.Rin  = 16'b1 << ra;
               state_d  = S_T0;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            state_d      = S_T0;
         end
         S_HALT: begin
            bus.halted = 1'b1;
            if (bus.run) state_d = S_T0;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: stimulus pushes hand-computed per-cycle strobe vectors,
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_control_sequencer;

   typedef struct packed {
      logic        PCout, Zlowout, Zhighout, MDRout;
      logic [15:0] Rout;
      logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
      logic [15:0] Rin;
      logic        IncPC, Read;
      logic [4:0]  alu_op;
      logic        halted, illegal;
   } outv_t;

   localparam int K_BIN = 0;
   localparam int K_UN  = 1;
   localparam int K_MD  = 2;
   localparam int K_NOP = 3;
   localparam int K_HLT = 4;
   localparam int K_ILL = 5;

   logic Clock = 1'b0;
   logic clear;

   control_sequencer_if cs_if ();

   control_sequencer dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (cs_if.master)
   );

   always #5 Clock = ~Clock;

   int    n_tests = 0;
   int    n_fail  = 0;
   outv_t exp_q[$];
   string name_q[$];
   logic  exp_ill  = 1'b0;
   bit    end_chk  = 1'b0;
   bit    end_done = 1'b0;

   function automatic outv_t z();
      outv_t v;
      v         = '0;
      v.illegal = exp_ill;
      return v;
   endfunction

   task automatic cyc(input outv_t e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge Clock);
      #1;
   endtask

   // Called in the first cycle of T0; returns in the cycle after the last step.
   task automatic instr(input logic [31:0] ir, input int kind, input logic [4:0] op,
                        input logic [15:0] rb1h, input logic [15:0] rc1h,
                        input logic [15:0] ra1h, input int unsigned waits,
                        input string nm);
      outv_t e;
      cs_if.IR = ir;
      e = z(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin_low = 1; e.alu_op = 5'h03;
      cyc(e, {nm, "/T0"});
      for (int unsigned w = 0; w < waits; w++) begin
         cs_if.mem_ready = 1'b0;
         e = z(); e.Zlowout = 1; e.Read = 1; e.MDRin = 1;
         cyc(e, {nm, "/T1wait"});
      end
      cs_if.mem_ready = 1'b1;
      e = z(); e.Zlowout = 1; e.Read = 1; e.MDRin = 1; e.PCin = 1;
      cyc(e, {nm, "/T1"});
      e = z(); e.MDRout = 1; e.IRin = 1;
      cyc(e, {nm, "/T2"});
      if (kind == K_NOP || kind == K_HLT || kind == K_ILL) begin
         cyc(z(), {nm, "/T3"});
      end else begin
         e = z(); e.Rout = rb1h; e.Yin = 1;
         cyc(e, {nm, "/T3"});
         e = z(); e.Rout = rc1h; e.alu_op = op; e.Zin_low = 1; e.Zin_high = 1;
         cyc(e, {nm, "/T4"});
         if (kind == K_MD) begin
            e = z(); e.Zlowout = 1; e.LOin = 1;
            cyc(e, {nm, "/T5"});
            e = z(); e.Zhighout = 1; e.HIin = 1;
            cyc(e, {nm, "/T6"});
         end else begin
            e = z(); e.Zlowout = 1; e.Rin = ra1h;
            cyc(e, {nm, "/T5"});
         end
      end
   endtask

   initial begin
      outv_t act, e;
      string nm;
      forever begin
         @(negedge Clock);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = '{cs_if.PCout, cs_if.Zlowout, cs_if.Zhighout, cs_if.MDRout, cs_if.Rout,
                    cs_if.MARin, cs_if.PCin, cs_if.MDRin, cs_if.IRin, cs_if.Yin,
                    cs_if.HIin, cs_if.LOin, cs_if.Zin_low, cs_if.Zin_high, cs_if.Rin,
                    cs_if.IncPC, cs_if.Read, cs_if.alu_op, cs_if.halted, cs_if.illegal};
            n_tests++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", nm, act, e);
            end
         end else if (end_chk && !end_done) begin
            n_tests++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
            end
            end_done = 1'b1;
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got no end of stimulus expected end within 20000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      outv_t e;
      clear           = 1'b0;
      cs_if.run       = 1'b1;
      cs_if.mem_ready = 1'b1;
      cs_if.IR        = '0;
      @(posedge Clock);
      #1;
      cyc(z(), "reset0");
      cyc(z(), "reset1");
      clear = 1'b1;
      cyc(z(), "release");
      cs_if.run = 1'b0;

      instr(32'h1A920000, K_BIN, 5'h03, 16'h0004, 16'h0010, 16'h0020, 0, "add");
      instr(32'h1A920000, K_BIN, 5'h03, 16'h0004, 16'h0010, 16'h0020, 3, "addw");
      instr({5'h0F, 4'd0, 4'd3, 4'd7, 15'd0}, K_MD, 5'h0F, 16'h0008, 16'h0080, 16'h0000, 0, "mul");
      instr({5'h10, 4'd0, 4'd1, 4'd2, 15'd0}, K_MD, 5'h10, 16'h0002, 16'h0004, 16'h0000, 1, "div");
      instr({5'h11, 4'd1, 4'd6, 4'd0, 15'd0}, K_UN, 5'h11, 16'h0040, 16'h0000, 16'h0002, 0, "neg");
      instr({5'h12, 4'd9, 4'd3, 4'd5, 15'd0}, K_UN, 5'h12, 16'h0008, 16'h0000, 16'h0200, 0, "not");
      instr({5'h04, 4'd7, 4'd7, 4'd7, 15'd0}, K_BIN, 5'h04, 16'h0080, 16'h0080, 16'h0080, 0, "sub");
      instr({5'h09, 4'd0, 4'd15, 4'd8, 15'd0}, K_BIN, 5'h09, 16'h8000, 16'h0100, 16'h0001, 2, "ror");
      instr({5'h1B, 27'd0}, K_NOP, 5'h00, 16'h0, 16'h0, 16'h0, 0, "nop");
      instr({5'h1C, 27'd0}, K_HLT, 5'h00, 16'h0, 16'h0, 16'h0, 0, "halt");

      e = z(); e.halted = 1;
      cyc(e, "halt/HALT0");
      cyc(e, "halt/HALT1");
      cs_if.run = 1'b1;
      cyc(e, "halt/HALT2");
      cs_if.run = 1'b0;

      instr({5'h1F, 27'd0}, K_ILL, 5'h00, 16'h0, 16'h0, 16'h0, 0, "ill");
      exp_ill = 1'b1;
      e = z(); e.halted = 1;
      cyc(e, "ill/HALT0");
      cs_if.run = 1'b1;
      cyc(e, "ill/HALT1");
      cs_if.run = 1'b0;

      e = z(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin_low = 1; e.alu_op = 5'h03;
      cyc(e, "rst/T0");
      cs_if.mem_ready = 1'b0;
      clear           = 1'b0;
      e = z(); e.Zlowout = 1; e.Read = 1; e.MDRin = 1;
      cyc(e, "rst/T1");
      exp_ill = 1'b0;
      cyc(z(), "rst/IDLE0");
      clear           = 1'b1;
      cs_if.mem_ready = 1'b1;
      cyc(z(), "rst/IDLE1");

      end_chk = 1'b1;
      wait (end_done);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
